// File: rtl/if_prefetch_buf.sv
// Instruction prefetch buffer: issues sequential fetches, queues in-order responses,
// and supports flush redirect, halt handshake and bus-error stop.
module if_prefetch_buf #(
  parameter int PC_W  = 32,
  parameter int IR_W  = 32,
  parameter int DEPTH = 4,
  parameter int OUTS  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PC_W-1:0]            pc_rtvec,
  input  logic                       halt_req,
  output logic                       halt_ack,
  input  logic                       flush_req,
  input  logic [PC_W-1:0]            flush_pc,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [PC_W-1:0]            req_pc,
  input  logic                       rsp_valid,
  output logic                       rsp_ready,
  input  logic [IR_W-1:0]            rsp_instr,
  input  logic                       rsp_err,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [IR_W-1:0]            o_ir,
  output logic [PC_W-1:0]            o_pc,
  output logic                       o_buserr,
  output logic [$clog2(DEPTH):0]     buf_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]  OUTS_C  = CW'(OUTS);
  localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [PC_W-1:0] ALIGN_M = ~PC_W'(3);
  localparam logic [PC_W-1:0] STEP    = PC_W'(4);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT, S_ERR} state_t;
  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [PC_W-1:0] pc;
    logic            err;
  } entry_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] fpc, epc;
  logic [CW-1:0]   outs_cnt, outs_nx, kill_cnt, kill_nx;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW:0]     occ;
  entry_t          mem [DEPTH];
  entry_t          head;
  logic            req_fire, rsp_fire, push, pop;

  assign rsp_ready = 1'b1;
  assign req_pc    = fpc;
  assign head      = mem[rd_ptr];
  assign o_valid   = (buf_cnt != '0);
  assign o_ir      = head.ir;
  assign o_pc      = head.pc;
  assign o_buserr  = o_valid & head.err;

  // Requests reserve a buffer slot at issue, so every response always has room.
  assign occ       = {1'b0, outs_cnt} + {1'b0, buf_cnt};
  assign req_valid = (state == S_RUN) & ~flush_req & ~halt_req &
                     (outs_cnt < OUTS_C) & (occ < DEPTH_C);
  assign req_fire  = req_valid & req_ready;
  assign rsp_fire  = rsp_valid;
  assign push      = rsp_fire & (kill_cnt == '0) & ~flush_req;
  assign pop       = o_valid & o_ready & ~flush_req;
  assign outs_nx   = outs_cnt + CW'(req_fire) - CW'(rsp_fire);

  always_comb begin
    kill_nx = kill_cnt;
    if (flush_req)                        kill_nx = outs_nx;
    else if (rsp_fire && kill_cnt != '0)  kill_nx = kill_cnt - CW'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_BOOT: state_nx = S_RUN;
      S_RUN: begin
        if (flush_req)            state_nx = halt_req ? S_HALT : S_RUN;
        else if (push && rsp_err) state_nx = S_ERR;
        else if (halt_req)        state_nx = S_HALT;
      end
      S_HALT: if (!halt_req)  state_nx = S_RUN;
      S_ERR:  if (flush_req)  state_nx = S_RUN;
      default: state_nx = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_BOOT;
      fpc      <= '0;
      epc      <= '0;
      outs_cnt <= '0;
      kill_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      buf_cnt  <= '0;
      halt_ack <= 1'b0;
    end else begin
      state    <= state_nx;
      outs_cnt <= outs_nx;
      kill_cnt <= kill_nx;
      // Ack only once nothing is in flight, dead responses included.
      halt_ack <= (state_nx == S_HALT) & (outs_nx == '0) & (kill_nx == '0);
      if (state == S_BOOT) begin
        fpc <= pc_rtvec & ALIGN_M;
        epc <= pc_rtvec & ALIGN_M;
      end
      if (flush_req) begin
        fpc     <= flush_pc & ALIGN_M;
        epc     <= flush_pc & ALIGN_M;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        buf_cnt <= '0;
      end else begin
        if (req_fire) fpc <= fpc + STEP;
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          epc    <= epc + STEP;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rsp_instr, epc, rsp_err};
  end

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Randomized bench for if_prefetch_buf: acts as the fetch memory and checks every
// cycle against a queue-based model of outstanding fetches and buffered instructions.
module tb_if_prefetch_buf;
  localparam int PC_W = 32, IR_W = 32, DEPTH = 4, OUTS = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0, rst = 1'b1;
  logic [PC_W-1:0] pc_rtvec, flush_pc, req_pc, o_pc;
  logic [IR_W-1:0] rsp_instr, o_ir;
  logic halt_req, halt_ack, flush_req, req_valid, req_ready;
  logic rsp_valid, rsp_ready, rsp_err, o_valid, o_ready, o_buserr;
  logic [CW-1:0] buf_cnt;

  always #5 clk = ~clk;

  if_prefetch_buf #(.PC_W(PC_W), .IR_W(IR_W), .DEPTH(DEPTH), .OUTS(OUTS)) dut (
    .clk(clk), .rst(rst), .pc_rtvec(pc_rtvec), .halt_req(halt_req), .halt_ack(halt_ack),
    .flush_req(flush_req), .flush_pc(flush_pc), .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_err(rsp_err), .o_valid(o_valid), .o_ready(o_ready), .o_ir(o_ir), .o_pc(o_pc),
    .o_buserr(o_buserr), .buf_cnt(buf_cnt)
  );

  typedef struct { logic [31:0] pc; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; logic err; } ent_t;

  pend_t pend_q[$];
  ent_t  buf_q[$];
  logic [31:0] nxt_req, nxt_push, rtvec_m, err_pc;
  bit booting, halted, errstop, ack_m, halt_lvl;
  int n_cmp = 0, n_bad = 0, n_req = 0;
  int rr_pct, or_pct, rsp_pct, err_pct;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic do_reset(input logic [31:0] vec);
    rst = 1'b1; pc_rtvec = vec; req_ready = 0; o_ready = 0; flush_req = 0; flush_pc = '0;
    halt_req = 0; rsp_valid = 0; rsp_instr = '0; rsp_err = 0; halt_lvl = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_buf_cnt", buf_cnt, 0);
    chk("rst_halt_ack", halt_ack, 0);
    chk("rst_o_buserr", o_buserr, 0);
    chk("rst_req_pc", req_pc, 0);
    pend_q.delete(); buf_q.delete();
    booting = 1; halted = 0; errstop = 0; ack_m = 0; rtvec_m = vec; n_req = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cycle(input bit fl, input logic [31:0] fpc_in);
    bit exp_rv, rf, pf, perr, st_run;
    pend_t p;
    req_ready = ($urandom_range(99) < rr_pct);
    o_ready   = ($urandom_range(99) < or_pct);
    flush_req = fl; flush_pc = fpc_in; halt_req = halt_lvl;
    rsp_valid = 0; rsp_instr = '0; rsp_err = 0;
    if (pend_q.size() != 0 && $urandom_range(99) < rsp_pct) begin
      rsp_valid = 1;
      rsp_instr = mem_rd(pend_q[0].pc);
      rsp_err   = (pend_q[0].pc == err_pc) || ($urandom_range(99) < err_pct);
    end
    @(negedge clk);
    st_run = !booting && !halted && !errstop;
    exp_rv = st_run && !fl && !halt_lvl && pend_q.size() < OUTS &&
             (pend_q.size() + buf_q.size()) < DEPTH;
    chk("req_valid", req_valid, exp_rv);
    if (exp_rv) chk("req_pc", req_pc, nxt_req);
    chk("buf_cnt", buf_cnt, buf_q.size());
    chk("o_valid", o_valid, buf_q.size() != 0);
    if (buf_q.size() != 0) begin
      chk("o_pc", o_pc, buf_q[0].pc);
      chk("o_ir", o_ir, buf_q[0].ir);
      chk("o_buserr", o_buserr, buf_q[0].err);
    end else chk("o_buserr_idle", o_buserr, 0);
    chk("halt_ack", halt_ack, ack_m);
    chk("rsp_ready", rsp_ready, 1);
    rf = exp_rv && req_ready;
    pf = (buf_q.size() != 0) && o_ready && !fl;
    @(posedge clk);
    if (booting) begin
      booting = 0; nxt_req = rtvec_m & 32'hFFFF_FFFC; nxt_push = nxt_req;
    end
    perr = 0;
    if (pf) void'(buf_q.pop_front());
    if (rsp_valid) begin
      p = pend_q.pop_front();
      if (!p.stale && !fl) begin
        buf_q.push_back('{nxt_push, rsp_instr, rsp_err});
        nxt_push += 32'd4;
        perr = rsp_err;
      end
    end
    if (rf) begin
      pend_q.push_back('{nxt_req, 1'b0});
      nxt_req += 32'd4;
      n_req++;
    end
    if (fl) begin
      buf_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1;
      nxt_req = fpc_in & 32'hFFFF_FFFC; nxt_push = nxt_req;
    end
    halted  = halt_lvl && (halted || (st_run && !perr));
    errstop = fl ? 1'b0 : (errstop || (st_run && perr));
    ack_m   = halted && pend_q.size() == 0;
    #1;
  endtask

  task automatic knobs(input int rr, input int orr, input int rs, input int er);
    rr_pct = rr; or_pct = orr; rsp_pct = rs; err_pct = er;
  endtask

  initial begin
    err_pc = 32'h1;
    knobs(100, 100, 100, 0);
    // Straight-line streaming from the boot vector.
    do_reset(32'h1000);
    repeat (20) cycle(0, '0);

    // Consumer stalled: fill exactly DEPTH, then one pop admits one request.
    do_reset(32'h1000);
    knobs(100, 0, 100, 0);
    repeat (12) cycle(0, '0);
    chk("fill_req_cnt", n_req, DEPTH);
    chk("fill_buf_cnt", buf_cnt, DEPTH);
    knobs(100, 100, 100, 0);
    cycle(0, '0);
    knobs(100, 0, 100, 0);
    repeat (6) cycle(0, '0);
    chk("refill_req_cnt", n_req, DEPTH + 1);

    // Flush with two fetches in flight; both must be discarded.
    do_reset(32'h1000);
    knobs(100, 0, 100, 0);
    for (int i = 0; i < 20 && n_req < 2; i++) cycle(0, '0);
    knobs(100, 0, 0, 0);
    for (int i = 0; i < 20 && n_req < 4; i++) cycle(0, '0);
    chk("pre_flush_outs", pend_q.size(), 2);
    cycle(1, 32'h2002);
    knobs(100, 100, 100, 0);
    repeat (15) cycle(0, '0);

    // Bus error on 0x1004 stops fetch until a redirect.
    do_reset(32'h1000);
    err_pc = 32'h1004;
    repeat (12) cycle(0, '0);
    chk("err_stopped_req_valid", req_valid, 0);
    err_pc = 32'h1;
    cycle(1, 32'h3000);
    repeat (12) cycle(0, '0);

    // Halt with fetches in flight, then release.
    do_reset(32'h1000);
    repeat (5) cycle(0, '0);
    knobs(100, 100, 0, 0);
    halt_lvl = 1;
    repeat (3) cycle(0, '0);
    knobs(100, 100, 100, 0);
    repeat (6) cycle(0, '0);
    chk("halt_ack_held", halt_ack, 1);
    halt_lvl = 0;
    repeat (10) cycle(0, '0);

    // PC wrap at the top of the address space.
    cycle(1, 32'hFFFF_FFFC);
    repeat (10) cycle(0, '0);

    // Randomized traffic with flushes, halts and bus errors.
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0)
        knobs($urandom_range(100), $urandom_range(100), $urandom_range(20, 100), 3);
      if ($urandom_range(99) < 3) halt_lvl = ~halt_lvl;
      if ($urandom_range(99) < 2) cycle(1, $urandom);
      else cycle(0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
